// File: rtl/drive_monitor.sv
// Drive monitor: tracks motion state, accumulates BCD mileage while moving,
// and drives the turn/hazard lamps including the stall warning blink.
//
// state | meaning
// IDLE  | manual driving off, lamps dark
// READY | powered, stationary
// FWD   | moving forward, mileage prescaler running
// REV   | moving in reverse, mileage prescaler running
// STALL | illegal-operation power-off, both lamps blink until the stall timer expires
module drive_monitor #(
    parameter int TICK_DIV     = 100000000,
    parameter int BLINK_DIV    = 50000000,
    parameter int STALL_CYCLES = 200000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [1:0]  dir,
    input  logic [1:0]  turn,
    input  logic        p_ok,
    input  logic        clr_mile,
    output logic [15:0] mile_bcd,
    output logic        led_l,
    output logic        led_r,
    output logic [2:0]  state_o,
    output logic        stall
);

    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        READY = 3'b001,
        FWD   = 3'b010,
        REV   = 3'b011,
        STALL = 3'b100
    } state_t;

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int SW = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;

    state_t          state_q, state_d;
    logic [TW-1:0]   presc_q, presc_d;
    logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
    logic [SW-1:0]   stall_cnt_q, stall_cnt_d;
    logic            phase_q, phase_d;
    logic [15:0]     mile_q, mile_d;
    logic            led_l_q, led_l_d;
    logic            led_r_q, led_r_d;
    logic            tick;
    logic            moving_q;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign moving_q = (state_q == FWD) || (state_q == REV);

    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = IDLE;
        end else if (!p_ok) begin
            state_d = STALL;
        end else begin
            case (state_q)
                IDLE:  state_d = READY;
                READY, FWD, REV: begin
                    case (dir)
                        2'b01:   state_d = FWD;
                        2'b10:   state_d = REV;
                        default: state_d = READY;
                    endcase
                end
                STALL: state_d = (stall_cnt_q == '0) ? READY : STALL;
                default: state_d = IDLE;
            endcase
        end
    end

    // Prescaler only runs while staying in the same motion state; any entry restarts it.
    always_comb begin
        presc_d = '0;
        tick    = 1'b0;
        if (moving_q && (state_d == state_q)) begin
            if (presc_q == TW'(TICK_DIV - 1)) begin
                tick = 1'b1;
            end else begin
                presc_d = presc_q + TW'(1);
            end
        end
    end

    // Stall timer is a down-counter reloaded on entry and on every p_ok drop.
    always_comb begin
        stall_cnt_d = '0;
        if (state_d == STALL) begin
            if ((state_q == STALL) && p_ok) begin
                stall_cnt_d = stall_cnt_q - SW'(1);
            end else begin
                stall_cnt_d = SW'(STALL_CYCLES - 1);
            end
        end
    end

    always_comb begin
        blink_cnt_d = '0;
        phase_d     = 1'b0;
        if ((state_d != IDLE) && (state_q != IDLE)) begin
            if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
                phase_d = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
                phase_d     = phase_q;
            end
        end
    end

    always_comb begin
        mile_d = mile_q;
        if (clr_mile) begin
            mile_d = '0;
        end else if (tick) begin
            mile_d = bcd_inc(mile_q);
        end
    end

    // Lamps are registered so turn never reaches an output combinationally.
    always_comb begin
        led_l_d = 1'b0;
        led_r_d = 1'b0;
        case (state_d)
            IDLE: begin
                led_l_d = 1'b0;
                led_r_d = 1'b0;
            end
            STALL: begin
                led_l_d = phase_d;
                led_r_d = phase_d;
            end
            default: begin
                led_l_d = phase_d & turn[0];
                led_r_d = phase_d & turn[1];
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            presc_q     <= '0;
            blink_cnt_q <= '0;
            stall_cnt_q <= '0;
            phase_q     <= 1'b0;
            mile_q      <= '0;
            led_l_q     <= 1'b0;
            led_r_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            blink_cnt_q <= blink_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            phase_q     <= phase_d;
            mile_q      <= mile_d;
            led_l_q     <= led_l_d;
            led_r_q     <= led_r_d;
        end
    end

    assign mile_bcd = mile_q;
    assign led_l    = led_l_q;
    assign led_r    = led_r_q;
    assign state_o  = state_q;
    assign stall    = (state_q == STALL);

endmodule

// File: tb/tb_drive_monitor.sv
// Self-checking bench for drive_monitor: a cycle model pushes expected outputs
// to a scoreboard queue, popped and compared one cycle later against the DUT.
module tb_drive_monitor;

    localparam int TICK_DIV     = 4;
    localparam int BLINK_DIV    = 2;
    localparam int STALL_CYCLES = 3;

    localparam int S_IDLE  = 0;
    localparam int S_READY = 1;
    localparam int S_FWD   = 2;
    localparam int S_REV   = 3;
    localparam int S_STALL = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  dir = 2'b00;
    logic [1:0]  turn = 2'b00;
    logic        p_ok = 1'b0;
    logic        clr_mile = 1'b0;
    logic [15:0] mile_bcd;
    logic        led_l;
    logic        led_r;
    logic [2:0]  state_o;
    logic        stall;

    drive_monitor #(
        .TICK_DIV     (TICK_DIV),
        .BLINK_DIV    (BLINK_DIV),
        .STALL_CYCLES (STALL_CYCLES)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .dir      (dir),
        .turn     (turn),
        .p_ok     (p_ok),
        .clr_mile (clr_mile),
        .mile_bcd (mile_bcd),
        .led_l    (led_l),
        .led_r    (led_r),
        .state_o  (state_o),
        .stall    (stall)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] mile;
        logic        l;
        logic        r;
        logic [2:0]  st;
        logic        stl;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    int   m_state, m_presc, m_mile, m_bcnt, m_scnt;
    logic m_phase, m_l, m_r;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic push_model();
        exp_t e;
        e.mile = to_bcd(m_mile);
        e.l    = m_l;
        e.r    = m_r;
        e.st   = 3'(m_state);
        e.stl  = (m_state == S_STALL);
        sb.push_back(e);
    endtask

    task automatic model_reset();
        m_state = S_IDLE;
        m_presc = 0;
        m_mile  = 0;
        m_bcnt  = 0;
        m_scnt  = 0;
        m_phase = 1'b0;
        m_l     = 1'b0;
        m_r     = 1'b0;
        push_model();
    endtask

    task automatic model_step();
        int nxt;
        bit mv, tick;
        if (!en)                         nxt = S_IDLE;
        else if (!p_ok)                  nxt = S_STALL;
        else if (m_state == S_IDLE)      nxt = S_READY;
        else if (m_state == S_STALL)     nxt = (m_scnt + 1 >= STALL_CYCLES) ? S_READY : S_STALL;
        else if (dir == 2'b01)           nxt = S_FWD;
        else if (dir == 2'b10)           nxt = S_REV;
        else                             nxt = S_READY;

        if (nxt == S_STALL) m_scnt = (m_state == S_STALL && p_ok) ? m_scnt + 1 : 0;
        else                m_scnt = 0;

        mv   = (m_state == S_FWD || m_state == S_REV) && (nxt == m_state);
        tick = mv && (m_presc == TICK_DIV - 1);
        m_presc = mv ? (m_presc + 1) % TICK_DIV : 0;

        if (clr_mile)  m_mile = 0;
        else if (tick) m_mile = (m_mile + 1) % 10000;

        if (nxt == S_IDLE || m_state == S_IDLE) begin
            m_bcnt  = 0;
            m_phase = 1'b0;
        end else begin
            m_bcnt++;
            if (m_bcnt == BLINK_DIV) begin
                m_bcnt  = 0;
                m_phase = ~m_phase;
            end
        end

        if (nxt == S_IDLE) begin
            m_l = 1'b0; m_r = 1'b0;
        end else if (nxt == S_STALL) begin
            m_l = m_phase; m_r = m_phase;
        end else begin
            m_l = m_phase & turn[0]; m_r = m_phase & turn[1];
        end
        m_state = nxt;
        push_model();
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_underflow: got empty queue expected an entry");
        end else begin
            e = sb.pop_front();
            check_eq("mile",  32'(mile_bcd), 32'(e.mile));
            check_eq("led_l", 32'(led_l),    32'(e.l));
            check_eq("led_r", 32'(led_r),    32'(e.r));
            check_eq("state", 32'(state_o),  32'(e.st));
            check_eq("stall", 32'(stall),    32'(e.stl));
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_out();
    endtask

    initial begin
        int cnt;
        int budget;
        int saved_mile;
        logic prev;

        // power-on reset
        #2;
        model_reset();
        compare_out();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // bring-up and first mileage ticks
        en = 1'b1; p_ok = 1'b1; dir = 2'b01;
        cycle();
        check_eq("r033_ready", 32'(state_o), 32'd1);
        cycle();
        check_eq("r033_fwd", 32'(state_o), 32'd2);
        for (int k = 1; k <= 10; k++) begin
            cycle();
            if (k == 3) check_eq("r033_mile_k3", 32'(mile_bcd), 32'h0000);
            if (k == 4) check_eq("r033_mile_k4", 32'(mile_bcd), 32'h0001);
            if (k == 8) check_eq("r033_mile_k8", 32'(mile_bcd), 32'h0002);
        end

        // turn lamps in READY
        dir = 2'b00; turn = 2'b01;
        cycle();
        prev = led_l; cnt = 0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (led_l !== prev) cnt++;
            prev = led_l;
        end
        check_eq("r037_left_toggles", 32'(cnt), 32'd4);
        turn = 2'b11;
        cycle();
        prev = led_r; cnt = 0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (led_r !== prev) cnt++;
            prev = led_r;
        end
        check_eq("r037_haz_toggles", 32'(cnt), 32'd4);

        // stall from FWD
        turn = 2'b00; dir = 2'b01;
        repeat (3) cycle();
        saved_mile = m_mile;
        p_ok = 1'b0;
        cycle();
        check_eq("r035_stall_state", 32'(state_o), 32'd4);
        check_eq("r035_stall_flag",  32'(stall),   32'd1);
        p_ok = 1'b1;
        repeat (2) cycle();
        check_eq("r035_still_stall", 32'(state_o), 32'd4);
        cycle();
        check_eq("r035_ready", 32'(state_o), 32'd1);
        check_eq("r035_mile",  32'(mile_bcd), 32'(to_bcd(saved_mile)));

        // en drop while stalled
        p_ok = 1'b0;
        cycle();
        p_ok = 1'b1; en = 1'b0;
        cycle();
        check_eq("r036_idle",  32'(state_o), 32'd0);
        check_eq("r036_lamps", 32'({led_l, led_r}), 32'd0);
        en = 1'b1;
        cycle();
        check_eq("r036_ready", 32'(state_o), 32'd1);

        // asynchronous reset mid-motion with prescaler at its last count
        dir = 2'b01;
        cycle();
        budget = 20;
        while (m_presc != TICK_DIV - 1 && budget > 0) begin
            cycle();
            budget--;
        end
        if (budget == 0) begin
            n_checks++; n_errors++;
            $display("FAIL r038_budget: got no prescaler terminal count expected one within 20 cycles");
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_out();
        check_eq("r038_mile", 32'(mile_bcd), 32'h0000);
        model_reset();
        @(posedge clk);
        #1;
        compare_out();
        rst_n = 1'b1;
        dir = 2'b00;
        cycle();
        check_eq("r038_first_edge", 32'(state_o), 32'd1);

        // preload 9999 in reverse, wrap, then clear on a tick
        clr_mile = 1'b1;
        cycle();
        clr_mile = 1'b0;
        dir = 2'b10;
        budget = 45000;
        while (m_mile != 9999 && budget > 0) begin
            cycle();
            budget--;
        end
        check_eq("r034_at_9999", 32'(mile_bcd), 32'h9999);
        budget = 10;
        while (m_mile != 0 && budget > 0) begin
            cycle();
            budget--;
        end
        check_eq("r034_wrap", 32'(mile_bcd), 32'h0000);
        budget = 40;
        while (!(m_mile == 5 && m_presc == TICK_DIV - 1) && budget > 0) begin
            cycle();
            budget--;
        end
        check_eq("r034_at_0005", 32'(mile_bcd), 32'h0005);
        clr_mile = 1'b1;
        cycle();
        clr_mile = 1'b0;
        check_eq("r034_clr_wins", 32'(mile_bcd), 32'h0000);
        cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
